// File: rtl/spare_logic_monitor.sv
// Snapshot-and-compare reader for the 42 spare-cell outputs: counts tie-off mismatches,
// records the lowest failing bit and can shift the captured snapshot out serially.
module spare_logic_monitor #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter bit          CHECK_FLOPS   = 1'b0
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [26:0] spare_xz,
    input  logic [3:0]  spare_xi,
    input  logic        spare_xib,
    input  logic [1:0]  spare_xna,
    input  logic [1:0]  spare_xno,
    input  logic [1:0]  spare_xmx,
    input  logic [1:0]  spare_xfq,
    input  logic [1:0]  spare_xfqn,
    input  logic        start,
    input  logic        dump_en,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [5:0]  err_count,
    output logic [5:0]  first_err_idx,
    output logic        sdo,
    output logic        sdo_valid,
    input  logic        sdo_ready
);

    typedef enum logic [2:0] {IDLE, SETTLE, SCAN, DUMP, DONE} state_t;

    localparam logic [41:0] EXP_VEC     = {2'b11, 2'b00, 2'b00, 2'b11, 2'b11, 1'b1, 4'hF, 27'h0};
    // Flop bits 41:38 power up undefined, so they are only compared when explicitly asked for.
    localparam logic [41:0] MASK        = CHECK_FLOPS ? {42{1'b1}} : {4'b0000, {38{1'b1}}};
    localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [5:0]  LAST_BIT    = 6'd41;
    localparam logic [5:0]  NO_ERR      = 6'h3F;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [5:0]  idx_q, idx_d;
    logic        dumpEn_q, dumpEn_d;
    logic [41:0] snap_q, snap_d;
    logic [5:0]  errCount_q, errCount_d;
    logic [5:0]  firstErr_q, firstErr_d;
    logic        pass_q, pass_d;
    logic [41:0] vec;

    assign vec = {spare_xfqn, spare_xfq, spare_xmx, spare_xno, spare_xna, spare_xib, spare_xi, spare_xz};

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            dumpEn_q   <= 1'b0;
            snap_q     <= '0;
            errCount_q <= '0;
            firstErr_q <= NO_ERR;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            dumpEn_q   <= dumpEn_d;
            snap_q     <= snap_d;
            errCount_q <= errCount_d;
            firstErr_q <= firstErr_d;
            pass_q     <= pass_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        dumpEn_d   = dumpEn_q;
        snap_d     = snap_q;
        errCount_d = errCount_q;
        firstErr_d = firstErr_q;
        pass_d     = pass_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = SETTLE;
                    cnt_d      = '0;
                    dumpEn_d   = dump_en;
                    errCount_d = '0;
                    firstErr_d = NO_ERR;
                    pass_d     = 1'b0;
                end
            end
            SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    snap_d  = vec;
                    idx_d   = '0;
                    state_d = SCAN;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            SCAN: begin
                if (MASK[idx_q] && (snap_q[idx_q] != EXP_VEC[idx_q])) begin
                    errCount_d = errCount_q + 6'd1;
                    if (firstErr_q == NO_ERR) begin
                        firstErr_d = idx_q;
                    end
                end
                if (idx_q == LAST_BIT) begin
                    idx_d = '0;
                    if (dumpEn_q) begin
                        state_d = DUMP;
                    end else begin
                        state_d = DONE;
                        pass_d  = (errCount_d == 6'd0);
                    end
                end else begin
                    idx_d = idx_q + 6'd1;
                end
            end
            DUMP: begin
                if (sdo_ready) begin
                    if (idx_q == LAST_BIT) begin
                        state_d = DONE;
                        pass_d  = (errCount_q == 6'd0);
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy          = (state_q == SETTLE) || (state_q == SCAN) || (state_q == DUMP);
    assign done          = (state_q == DONE);
    assign sdo_valid     = (state_q == DUMP);
    assign sdo           = sdo_valid & snap_q[idx_q];
    assign pass          = pass_q;
    assign err_count     = errCount_q;
    assign first_err_idx = firstErr_q;

endmodule
